// File: rtl/core_mem_arbiter_pkg.sv
// Shared types and default constants for the core memory arbiter.
// Also holds the helper that picks a 32-bit instruction word out of a 64-bit memory beat.
package core_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

  localparam int DEF_XLEN           = 64;
  localparam int DEF_D_MAX_BURST    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  // Address bit 2 selects which half of a 64-bit beat holds the instruction.
  function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic hi);
    logic [31:0] word;
    if (hi) begin
      word = beat[63:32];
    end else begin
      word = beat[31:0];
    end
    return word;
  endfunction

endpackage

// File: rtl/core_mem_arbiter.sv
// Arbitrates instruction and data ports onto one memory port.
// D has priority, but a bounded D streak lets a waiting fetch through; stalled grants time out.
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int XLEN           = DEF_XLEN,
  parameter int D_MAX_BURST    = DEF_D_MAX_BURST,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] imem_addr,
  input  logic            imem_req,
  output logic [31:0]     imem_rdata,
  output logic            imem_ready,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [7:0]      dmem_wmask,
  input  logic            dmem_req,
  input  logic            dmem_we,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  output logic            mem_req,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            bus_err
);

  localparam int SW = $clog2(D_MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(D_MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      wmask_q, wmask_d;
  logic            we_q, we_d;
  logic [31:0]     imem_rdata_q, imem_rdata_d;
  logic [XLEN-1:0] dmem_rdata_q, dmem_rdata_d;
  logic            imem_ready_q, imem_ready_d;
  logic            dmem_ready_q, dmem_ready_d;
  logic            bus_err_q, bus_err_d;

  // Next-state, grant latching, streak/timeout bookkeeping and response capture.
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    we_d         = we_q;
    imem_rdata_d = imem_rdata_q;
    dmem_rdata_d = dmem_rdata_q;
    imem_ready_d = 1'b0;
    dmem_ready_d = 1'b0;
    bus_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req && !(imem_req && (streak_q == STREAK_MAX))) begin
          state_d = ST_GRANT_D;
          addr_d  = dmem_addr;
          wdata_d = dmem_wdata;
          wmask_d = dmem_wmask;
          we_d    = dmem_we;
          tmo_d   = {TW{1'b0}};
          // Only D grants that made a waiting fetch wait count towards the streak.
          if (imem_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
          end else begin
            streak_d = streak_q;
          end
        end else if (imem_req) begin
          state_d  = ST_GRANT_I;
          addr_d   = imem_addr;
          wdata_d  = {XLEN{1'b0}};
          wmask_d  = 8'h00;
          we_d     = 1'b0;
          tmo_d    = {TW{1'b0}};
          streak_d = {SW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_ready) begin
          state_d = ST_RESP;
          if (state_q == ST_GRANT_I) begin
            imem_rdata_d = fetch_word(mem_rdata[63:0], addr_q[2]);
            imem_ready_d = 1'b1;
          end else begin
            dmem_rdata_d = mem_rdata;
            dmem_ready_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_RESP;
          bus_err_d = 1'b1;
          if (state_q == ST_GRANT_I) begin
            imem_rdata_d = 32'h0000_0000;
            imem_ready_d = 1'b1;
          end else begin
            dmem_rdata_d = {XLEN{1'b0}};
            dmem_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      streak_q     <= {SW{1'b0}};
      tmo_q        <= {TW{1'b0}};
      addr_q       <= {XLEN{1'b0}};
      wdata_q      <= {XLEN{1'b0}};
      wmask_q      <= 8'h00;
      we_q         <= 1'b0;
      imem_rdata_q <= 32'h0000_0000;
      dmem_rdata_q <= {XLEN{1'b0}};
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      we_q         <= we_d;
      imem_rdata_q <= imem_rdata_d;
      dmem_rdata_q <= dmem_rdata_d;
      imem_ready_q <= imem_ready_d;
      dmem_ready_q <= dmem_ready_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req    = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign mem_we     = we_q;
  assign imem_rdata = imem_rdata_q;
  assign imem_ready = imem_ready_q;
  assign dmem_rdata = dmem_rdata_q;
  assign dmem_ready = dmem_ready_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_core_mem_arbiter;

  localparam int DMAX = 4;
  localparam int TMO  = 8;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_rdata;
  logic        dmem_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  int n_checks;
  int n_pass;
  int streak_m;

  core_mem_arbiter #(
    .XLEN(64),
    .D_MAX_BURST(DMAX),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction starting in an IDLE cycle. lat < 0 means memory never answers.
  task automatic run_txn(input bit req_i, input bit req_d,
                         input logic [63:0] iaddr, input logic [63:0] daddr,
                         input logic [63:0] dwdata, input logic [7:0] dwmask,
                         input bit dwe, input int lat, input logic [63:0] rdata,
                         input bit drop, input bit hold_after, output bit obs_d);
    bit          win_d;
    int          wait_n;
    logic [63:0] exp_rd;
    logic [63:0] exp_addr;
    check_val("idle_mem_req", mem_req, 64'd0);
    check_val("idle_ready", {imem_ready, dmem_ready}, 64'd0);
    imem_req   = req_i;
    dmem_req   = req_d;
    imem_addr  = iaddr;
    dmem_addr  = daddr;
    dmem_wdata = dwdata;
    dmem_wmask = dwmask;
    dmem_we    = dwe;
    mem_ready  = 1'b0;
    // Model: D wins unless I is waiting and D has had its full burst.
    win_d = req_d && !(req_i && streak_m == DMAX);
    if (win_d) begin
      if (req_i && streak_m < DMAX) streak_m++;
    end else begin
      streak_m = 0;
    end
    exp_addr = win_d ? daddr : iaddr;
    step();
    obs_d = (mem_addr == daddr);
    check_val("grant_mem_req", mem_req, 64'd1);
    check_val("grant_port", obs_d, win_d);
    check_val("grant_addr", mem_addr, exp_addr);
    check_val("grant_we", mem_we, win_d ? dwe : 1'b0);
    check_val("grant_wmask", mem_wmask, win_d ? dwmask : 8'h00);
    if (win_d) check_val("grant_wdata", mem_wdata, dwdata);
    if (drop) begin
      if (win_d) dmem_req = 1'b0;
      else       imem_req = 1'b0;
    end
    imem_addr  = ~iaddr;
    dmem_addr  = ~daddr;
    dmem_wdata = ~dwdata;
    wait_n = (lat < 0) ? TMO - 1 : lat;
    for (int k = 0; k < wait_n; k++) begin
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      step();
      check_val("wait_mem_req", mem_req, 64'd1);
      check_val("wait_addr", mem_addr, exp_addr);
      check_val("wait_ready", {imem_ready, dmem_ready}, 64'd0);
    end
    mem_ready = (lat >= 0);
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (lat < 0)    exp_rd = 64'd0;
    else if (win_d) exp_rd = rdata;
    else if (iaddr[2]) exp_rd = {32'd0, rdata[63:32]};
    else            exp_rd = {32'd0, rdata[31:0]};
    check_val("resp_mem_req", mem_req, 64'd0);
    check_val("resp_imem_ready", imem_ready, !win_d);
    check_val("resp_dmem_ready", dmem_ready, win_d);
    check_val("resp_bus_err", bus_err, (lat < 0));
    check_val("resp_rdata", win_d ? dmem_rdata : {32'd0, imem_rdata}, exp_rd);
    if (hold_after) begin
      imem_req  = req_i;
      dmem_req  = req_d;
      imem_addr = iaddr;
      dmem_addr = daddr;
    end else begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
    step();
    check_val("post_ready", {imem_ready, dmem_ready}, 64'd0);
    check_val("post_bus_err", bus_err, 64'd0);
  endtask

  initial begin
    bit obs;
    bit ri, rd;
    int lat;
    n_checks   = 0;
    n_pass     = 0;
    streak_m   = 0;
    rst_n      = 1'b0;
    imem_addr  = 64'd0;
    imem_req   = 1'b0;
    dmem_addr  = 64'd0;
    dmem_wdata = 64'd0;
    dmem_wmask = 8'h00;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    mem_rdata  = 64'd0;
    mem_ready  = 1'b0;
    repeat (3) step();
    check_val("rst_ctrl", {mem_req, mem_we, imem_ready, dmem_ready, bus_err}, 64'd0);
    check_val("rst_mem_addr", mem_addr, 64'd0);
    check_val("rst_mem_wdata", mem_wdata, 64'd0);
    check_val("rst_mem_wmask", mem_wmask, 64'd0);
    check_val("rst_rdata", dmem_rdata | {32'd0, imem_rdata}, 64'd0);
    rst_n = 1'b1;
    step();

    // Both ports held continuously: D,D,D,D,I repeating.
    for (int j = 0; j < 10; j++) begin
      run_txn(1'b1, 1'b1, 64'h0000_0000_0000_1000, 64'h8000_0000_0000_2000,
              64'h1111, 8'hFF, 1'b1, 0, {$urandom, $urandom}, 1'b0, 1'b1, obs);
      check_val("burst_order", obs, ((j % 5) != 4));
    end

    // Isolated fetch from the upper half of a beat.
    run_txn(1'b1, 1'b0, 64'h4, 64'h8000_0000_0000_0000, 64'd0, 8'h00, 1'b0,
            0, 64'hDEADBEEF_00500093, 1'b0, 1'b0, obs);
    // Store with partial byte mask.
    run_txn(1'b0, 1'b1, 64'h0, 64'h10, 64'h8, 8'h0F, 1'b1,
            2, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, obs);
    // Memory never answers.
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_0000_0000_0040, 64'h5, 8'h01, 1'b0,
            -1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, obs);
    // Requester drops req mid-transaction.
    run_txn(1'b1, 1'b0, 64'h8, 64'h8000_0000_0000_0000, 64'd0, 8'h00, 1'b0,
            3, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0, obs);

    // Spurious mem_ready while idle.
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_val("spur_mem_req", mem_req, 64'd0);
    check_val("spur_ready", {imem_ready, dmem_ready, bus_err}, 64'd0);
    step();
    check_val("spur_ready2", {mem_req, imem_ready, dmem_ready, bus_err}, 64'd0);

    // Reset while a D grant is outstanding.
    dmem_req   = 1'b1;
    dmem_addr  = 64'h8000_0000_0000_0080;
    dmem_wdata = 64'h77;
    dmem_we    = 1'b1;
    dmem_wmask = 8'hF0;
    step();
    check_val("rstmid_grant", mem_req, 64'd1);
    rst_n = 1'b0;
    step();
    check_val("rstmid_mem_req", mem_req, 64'd0);
    check_val("rstmid_ready", {imem_ready, dmem_ready, bus_err}, 64'd0);
    check_val("rstmid_addr", mem_addr, 64'd0);
    check_val("rstmid_rdata", dmem_rdata | {32'd0, imem_rdata}, 64'd0);
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rst_n    = 1'b1;
    streak_m = 0;
    step();
    check_val("rstmid_idle", {mem_req, imem_ready, dmem_ready}, 64'd0);

    // Randomized traffic.
    for (int j = 0; j < 40; j++) begin
      ri  = $urandom_range(0, 1);
      rd  = $urandom_range(0, 1);
      if (!ri && !rd) rd = 1'b1;
      lat = $urandom_range(0, 9);
      if (lat > 7) lat = -1;
      run_txn(ri, rd, {32'h0, $urandom}, {32'h8000_0000, $urandom}, {$urandom, $urandom},
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), lat, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data/address width of the D-port and memory port.
REQ-002 Parameter D_MAX_BURST, default 4, maximum consecutive D grants while I is pending.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, maximum cycles to wait for mem_ready.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 imem_addr  input  XLEN  instruction fetch byte address.
REQ-008 imem_req  input  1  fetch request, held until imem_ready.
REQ-009 imem_rdata  output  32  fetched instruction.
REQ-010 imem_ready  output  1  one-cycle fetch completion pulse.
REQ-011 dmem_addr, dmem_wdata  input  XLEN each  data address and store data.
REQ-012 dmem_wmask  input  8  store byte enables.
REQ-013 dmem_req, dmem_we  input  1 each  data request, held until dmem_ready; write enable.
REQ-014 dmem_rdata  output  XLEN  load data.
REQ-015 dmem_ready  output  1  one-cycle data completion pulse.
REQ-016 mem_addr, mem_wdata  output  XLEN each; mem_wmask  output  8; mem_req, mem_we  output  1 each: shared memory port.
REQ-017 mem_rdata  input  XLEN; mem_ready  input  1: memory response data and completion.
REQ-018 bus_err  output  1  pulses with the ready that ends a timed-out transaction.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, GRANT_I, GRANT_D and RESP.
REQ-020 In IDLE, with only imem_req high, the FSM SHALL go to GRANT_I; with only dmem_req high, to GRANT_D.
REQ-021 In IDLE, with both requests high, D SHALL win unless d_streak == D_MAX_BURST, in which case I SHALL win.
REQ-022 d_streak SHALL increment (saturating) on each D grant made while imem_req is high, and clear on every I grant.
REQ-023 On a grant, the requester's address, wdata, wmask and we SHALL be latched; I grants SHALL use we=0 and wmask=0.
REQ-024 mem_req SHALL be high exactly while in GRANT_I or GRANT_D, and mem_* SHALL be driven from latched values only.
REQ-025 mem_ready SHALL be sampled only in GRANT states and ignored elsewhere.
REQ-026 On mem_ready in a GRANT state, the FSM SHALL go to RESP and register the response data.
REQ-027 For I transactions, imem_rdata SHALL be mem_rdata[63:32] when latched addr[2]=1, else mem_rdata[31:0].
REQ-028 In RESP, the granted requester's ready SHALL be high for exactly one cycle, and the FSM SHALL then go to IDLE.
REQ-029 In RESP, requests SHALL be ignored; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-030 Minimum latency SHALL be: request sampled in cycle N, mem_req high in N+1, mem_ready in N+1, ready in N+2.
REQ-031 The timeout counter SHALL clear on every grant; if TIMEOUT_CYCLES cycles pass in a GRANT state without mem_ready, the FSM SHALL go to RESP with rdata=0 and bus_err=1.
REQ-032 A requester dropping req mid-transaction SHALL NOT abort it; its ready pulse SHALL still be issued.
REQ-033 The ready outputs SHALL never be high in the same cycle as each other, and never outside RESP.

Reset
REQ-034 While rst_n is low at a clock edge, the FSM SHALL be IDLE and d_streak and the timeout counter SHALL be 0.
REQ-035 While in reset, every output, including mem_addr, mem_wdata, imem_rdata and dmem_rdata, SHALL be 0.
REQ-036 Reset asserted mid-transaction SHALL drop mem_req at the next edge and SHALL NOT produce a ready pulse.

Structure
REQ-037 The package core_mem_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-038 Arbitration, streak and timeout logic SHALL be inline; no sub-module is used.

Verification
REQ-039 Isolated I fetch: addr 0x4, mem_rdata 0xDEADBEEF_00500093 returned in one cycle -> imem_rdata 0xDEADBEEF, imem_ready at N+2.
REQ-040 Both requests held continuously with D_MAX_BURST=4 -> grant order D,D,D,D,I, repeating.
REQ-041 D store addr 0x10, wdata 0x8, wmask 0x0F -> mem_we=1 and mem_wmask 0x0F while mem_req is high; dmem_ready once.
REQ-042 mem_ready never asserted, TIMEOUT_CYCLES=8 -> dmem_ready with bus_err=1 and dmem_rdata 0 exactly 8 cycles after mem_req rises.
REQ-043 rst_n low while in GRANT_D -> mem_req=0 at the next edge, no dmem_ready, FSM in IDLE.
REQ-044 mem_ready asserted while the FSM is in IDLE -> no state change and no ready output.
